// File: rtl/apb_mem_arbiter_if.sv
// APB bus bundle between the arbiter (master) and the memory (slave).
interface apb_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE,
        output PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE,
        input  PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_mem_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port,
// with a wait-state timeout that aborts stalled transfers.
module apb_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_done,
    output logic                    req_err,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              gnt,
    apb_mem_arbiter_if.master       apb
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_next;
    logic          last;
    logic [1:0]    elig;
    logic          pick;

    // The requester finishing this cycle still holds req_valid; mask it
    // so it is not granted twice for one request.
    always_comb begin
        elig      = req_valid & ~req_done;
        pick      = (elig == 2'b11) ? ~last : elig[1];
        wait_next = wait_cnt + 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            last        <= 1'b1;
            gnt         <= '0;
            req_done    <= '0;
            req_err     <= 1'b0;
            rdata       <= '0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
        end else begin
            req_done <= '0;
            req_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|elig) begin
                        state       <= SETUP;
                        wait_cnt    <= '0;
                        last        <= pick;
                        gnt         <= pick ? 2'b10 : 2'b01;
                        apb.PSEL    <= 1'b1;
                        apb.PENABLE <= 1'b0;
                        apb.PWRITE  <= req_write[pick];
                        apb.PADDR   <= pick
                            ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : req_addr[ADDR_WIDTH-1:0];
                        apb.PWDATA  <= pick
                            ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                            : req_wdata[DATA_WIDTH-1:0];
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    apb.PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (apb.PREADY) begin
                        state       <= IDLE;
                        gnt         <= '0;
                        req_done    <= gnt;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        if (!apb.PWRITE) rdata <= apb.PRDATA;
                    end else begin
                        wait_cnt <= wait_next;
                        if (wait_next == TO) begin
                            state       <= IDLE;
                            gnt         <= '0;
                            req_done    <= gnt;
                            req_err     <= 1'b1;
                            apb.PSEL    <= 1'b0;
                            apb.PENABLE <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
